// File: rtl/onehot_q_reader.sv
// onehot_q_reader: read end of a one-hot-pointer circular queue.
// Owns rd_ptr/rd_wrap, detects empty, and stages one entry behind a valid/ready handshake.
//
// Ports:
//   clk      rising-edge clock
//   clr      asynchronous active-low reset
//   entries  flattened queue storage from the writer (entry k at [k*WIDTH +: WIDTH])
//   wr_ptr   writer one-hot write pointer
//   wr_wrap  writer wrap bit
//   flush    synchronous discard of queued and staged entries
//   ready    consumer accepts dout this cycle
//   valid    dout holds a valid entry
//   dout     staged entry
//   rd_ptr   one-hot read pointer (next slot to read)
//   rd_wrap  read wrap bit
module onehot_q_reader #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   clr,
    input  logic [DEPTH*WIDTH-1:0] entries,
    input  logic [DEPTH-1:0]       wr_ptr,
    input  logic                   wr_wrap,
    input  logic                   flush,
    input  logic                   ready,
    output logic                   valid,
    output logic [WIDTH-1:0]       dout,
    output logic [DEPTH-1:0]       rd_ptr,
    output logic                   rd_wrap
);

    logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic             rd_wrap_q, rd_wrap_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic             empty;
    logic             stage_free;
    logic             deq;
    logic [WIDTH-1:0] sel_word;

    // Equal pointers mean empty only when both sides are on the same lap.
    assign empty      = (rd_ptr_q == wr_ptr) && (rd_wrap_q == wr_wrap);
    assign stage_free = !valid_q || ready;
    assign deq        = stage_free && !empty && !flush;

    // One-hot AND-OR read mux: no binary decode of the pointer.
    always_comb begin
        sel_word = '0;
        for (int k = 0; k < DEPTH; k++) begin
            sel_word = sel_word
                     | (entries[k*WIDTH +: WIDTH] & {WIDTH{rd_ptr_q[k]}});
        end
    end

    always_comb begin
        rd_ptr_d  = rd_ptr_q;
        rd_wrap_d = rd_wrap_q;
        valid_d   = valid_q;
        dout_d    = dout_q;
        if (flush) begin
            // Resync to the writer; the staged entry is dropped.
            valid_d   = 1'b0;
            rd_ptr_d  = wr_ptr;
            rd_wrap_d = wr_wrap;
        end else if (deq) begin
            dout_d    = sel_word;
            valid_d   = 1'b1;
            rd_ptr_d  = {rd_ptr_q[DEPTH-2:0], rd_ptr_q[DEPTH-1]};
            rd_wrap_d = rd_wrap_q ^ rd_ptr_q[DEPTH-1];
        end else if (stage_free) begin
            valid_d = 1'b0;
        end
    end

    // rd_ptr bit 0 resets to 1; everything else resets to 0.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rd_ptr_q  <= DEPTH'(1);
            rd_wrap_q <= 1'b0;
            valid_q   <= 1'b0;
            dout_q    <= '0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            rd_wrap_q <= rd_wrap_d;
            valid_q   <= valid_d;
            dout_q    <= dout_d;
        end
    end

    assign valid   = valid_q;
    assign dout    = dout_q;
    assign rd_ptr  = rd_ptr_q;
    assign rd_wrap = rd_wrap_q;

endmodule

// File: tb/tb_onehot_q_reader.sv
// tb_onehot_q_reader: directed vector bench for onehot_q_reader.
// Table of per-edge vectors plus hand sequences for reset, backpressure, full drain.
module tb_onehot_q_reader;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic                          clk;
    logic                          clr;
    logic [DEPTH-1:0][WIDTH-1:0]   ent;
    logic [DEPTH-1:0]              wr_ptr;
    logic                          wr_wrap;
    logic                          flush;
    logic                          ready;
    logic                          valid;
    logic [WIDTH-1:0]              dout;
    logic [DEPTH-1:0]              rd_ptr;
    logic                          rd_wrap;

    int checks = 0;
    int errors = 0;

    onehot_q_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk     (clk),
        .clr     (clr),
        .entries (ent),
        .wr_ptr  (wr_ptr),
        .wr_wrap (wr_wrap),
        .flush   (flush),
        .ready   (ready),
        .valid   (valid),
        .dout    (dout),
        .rd_ptr  (rd_ptr),
        .rd_wrap (rd_wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             clr;
        logic             flush;
        logic             ready;
        logic [DEPTH-1:0] wp;
        logic             ww;
        logic [WIDTH-1:0] e0;
        logic             v;
        logic [WIDTH-1:0] d;
        logic [DEPTH-1:0] rp;
        logic             rw;
    } vec_t;

    vec_t tbl[16];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [WIDTH-1:0] d,
                           input logic [DEPTH-1:0] rp, input logic rw);
        chk({tag, " valid"},   32'(valid),   32'(v));
        chk({tag, " dout"},    32'(dout),    32'(d));
        chk({tag, " rd_ptr"},  32'(rd_ptr),  32'(rp));
        chk({tag, " rd_wrap"}, 32'(rd_wrap), 32'(rw));
        chk({tag, " onehot"},  32'($onehot(rd_ptr)), 32'd1);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        clr = 1'b0; flush = 1'b0; ready = 1'b0;
        wr_ptr = 8'h01; wr_wrap = 1'b0;
        @(negedge clk);
        clr = 1'b1;
    endtask

    initial begin
        clr = 1'b0; flush = 1'b0; ready = 1'b0;
        wr_ptr = 8'h01; wr_wrap = 1'b0;
        for (int k = 0; k < DEPTH; k++) ent[k] = WIDTH'(16'h0100 + k);

        //          clr flsh rdy  wp     ww    e0        v     d         rp     rw
        tbl[0]  = '{1'b0,1'b0,1'b1,8'h01,1'b0,16'h0100,1'b0,16'h0000,8'h01,1'b0};
        tbl[1]  = '{1'b1,1'b0,1'b1,8'h01,1'b0,16'h0100,1'b0,16'h0000,8'h01,1'b0};
        tbl[2]  = '{1'b1,1'b0,1'b1,8'h02,1'b0,16'h0100,1'b1,16'h0100,8'h02,1'b0};
        tbl[3]  = '{1'b1,1'b0,1'b1,8'h04,1'b0,16'h0100,1'b1,16'h0101,8'h04,1'b0};
        tbl[4]  = '{1'b1,1'b0,1'b1,8'h08,1'b0,16'h0100,1'b1,16'h0102,8'h08,1'b0};
        tbl[5]  = '{1'b1,1'b0,1'b1,8'h10,1'b0,16'h0100,1'b1,16'h0103,8'h10,1'b0};
        tbl[6]  = '{1'b1,1'b0,1'b1,8'h20,1'b0,16'h0100,1'b1,16'h0104,8'h20,1'b0};
        tbl[7]  = '{1'b1,1'b0,1'b1,8'h40,1'b0,16'h0100,1'b1,16'h0105,8'h40,1'b0};
        tbl[8]  = '{1'b1,1'b0,1'b1,8'h80,1'b0,16'h0100,1'b1,16'h0106,8'h80,1'b0};
        tbl[9]  = '{1'b1,1'b0,1'b1,8'h01,1'b1,16'h0100,1'b1,16'h0107,8'h01,1'b1};
        tbl[10] = '{1'b1,1'b0,1'b1,8'h02,1'b1,16'h0200,1'b1,16'h0200,8'h02,1'b1};
        tbl[11] = '{1'b1,1'b0,1'b1,8'h02,1'b1,16'h0200,1'b0,16'h0200,8'h02,1'b1};
        tbl[12] = '{1'b1,1'b0,1'b0,8'h40,1'b1,16'h0200,1'b1,16'h0101,8'h04,1'b1};
        tbl[13] = '{1'b1,1'b1,1'b1,8'h40,1'b1,16'h0200,1'b0,16'h0101,8'h40,1'b1};
        tbl[14] = '{1'b1,1'b0,1'b1,8'h40,1'b1,16'h0200,1'b0,16'h0101,8'h40,1'b1};
        tbl[15] = '{1'b1,1'b0,1'b1,8'h80,1'b1,16'h0200,1'b1,16'h0106,8'h80,1'b1};

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            clr = tbl[i].clr; flush = tbl[i].flush; ready = tbl[i].ready;
            wr_ptr = tbl[i].wp; wr_wrap = tbl[i].ww; ent[0] = tbl[i].e0;
            step();
            chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].d, tbl[i].rp, tbl[i].rw);
        end

        // Asynchronous reset while an entry is staged.
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk_out("rst_async", 1'b0, 16'h0000, 8'h01, 1'b0);
        step();
        chk_out("rst_hold", 1'b0, 16'h0000, 8'h01, 1'b0);
        @(negedge clk);
        clr = 1'b1; wr_ptr = 8'h01; wr_wrap = 1'b0; ready = 1'b1;
        step();
        chk_out("rst_release", 1'b0, 16'h0000, 8'h01, 1'b0);

        // Single entry.
        @(negedge clk);
        ent[0] = 16'hA5A5; wr_ptr = 8'h02;
        step();
        chk_out("single_a", 1'b1, 16'hA5A5, 8'h02, 1'b0);
        step();
        chk_out("single_b", 1'b0, 16'hA5A5, 8'h02, 1'b0);

        // Backpressure with three entries.
        do_reset();
        ent[0] = 16'h0011; ent[1] = 16'h0022; ent[2] = 16'h0033;
        wr_ptr = 8'h08; ready = 1'b0;
        step();
        chk_out("bp_load", 1'b1, 16'h0011, 8'h02, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step();
            chk_out($sformatf("bp_stall%0d", c), 1'b1, 16'h0011, 8'h02, 1'b0);
        end
        @(negedge clk);
        ready = 1'b1;
        step();
        chk_out("bp_22", 1'b1, 16'h0022, 8'h04, 1'b0);
        step();
        chk_out("bp_33", 1'b1, 16'h0033, 8'h08, 1'b0);
        step();
        chk_out("bp_idle", 1'b0, 16'h0033, 8'h08, 1'b0);

        // Full queue drains all eight slots.
        do_reset();
        for (int k = 0; k < DEPTH; k++) ent[k] = WIDTH'(16'h0500 + k);
        wr_ptr = 8'h01; wr_wrap = 1'b1; ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            logic [DEPTH-1:0] erp;
            erp = DEPTH'(1) << ((k + 1) % DEPTH);
            step();
            chk_out($sformatf("full%0d", k), 1'b1, WIDTH'(16'h0500 + k), erp, (k == DEPTH - 1));
        end
        step();
        chk_out("full_done", 1'b0, 16'h0507, 8'h01, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
